// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with runtime seed load, lock-up interception
// and a single-entry valid/ready output register.
module lfsr_gen #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [63:0] TAPS    = 64'h8020_0003,
  parameter bit          XNOR    = 1'b1,
  parameter logic [63:0] SEED    = 64'h0FFF_0FFF,
  parameter int unsigned STEPS   = 1,
  parameter logic [63:0] OR_MASK = 64'h8000_8000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MASK_W = OR_MASK[WIDTH-1:0];
  // The one state the feedback function maps onto itself.
  localparam logic [WIDTH-1:0] LOCK_W = XNOR ? '1 : '0;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic fb;
    fb = (^(s & TAPS_W)) ^ XNOR;
    return {s[WIDTH-2:0], fb};
  endfunction

  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] fire_val;
  logic [WIDTH-1:0] load_val;
  logic             fire;
  logic             fire_lock;
  logic             load_lock;

  // Unrolled STEPS-fold advance plus lock-value substitution for load and fire.
  always_comb begin
    adv = state;
    for (int unsigned i = 0; i < STEPS; i++) begin
      adv = lfsr_step(adv);
    end
    fire      = enable & (~out_valid | out_ready);
    fire_lock = (adv == LOCK_W);
    fire_val  = fire_lock ? SEED_W : adv;
    load_lock = (seed_in == LOCK_W);
    load_val  = load_lock ? SEED_W : seed_in;
  end

  // State, output word and handshake register; priority reset > load > fire > drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEED_W;
      out_data  <= '0;
      out_valid <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      lockup <= 1'b0;
      if (load) begin
        state     <= load_val;
        out_valid <= 1'b0;
        lockup    <= load_lock;
      end else if (fire) begin
        state     <= fire_val;
        out_data  <= fire_val | MASK_W;
        out_valid <= 1'b1;
        lockup    <= fire_lock;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: vector table on the default build, scoreboard on a
// STEPS=2 build, and period / lock-up sequences on a 4-bit XOR build.
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance 0: defaults
  logic        rst0, en0, ld0, rdy0, v0, lk0;
  logic [31:0] seed0, d0, st0;
  // Instance 1: STEPS=2
  logic        rst1, en1, ld1, rdy1, v1, lk1;
  logic [31:0] seed1, d1, st1;
  // Instance 2: 4-bit XOR
  logic        rst2, en2, ld2, rdy2, v2, lk2;
  logic [3:0]  seed2, d2, st2;

  lfsr_gen u0 (
    .clk(clk), .reset(rst0), .enable(en0), .load(ld0), .seed_in(seed0),
    .out_ready(rdy0), .out_valid(v0), .out_data(d0), .state(st0), .lockup(lk0)
  );

  lfsr_gen #(.STEPS(2)) u1 (
    .clk(clk), .reset(rst1), .enable(en1), .load(ld1), .seed_in(seed1),
    .out_ready(rdy1), .out_valid(v1), .out_data(d1), .state(st1), .lockup(lk1)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(64'h9), .XNOR(1'b0), .SEED(64'h1), .STEPS(1),
             .OR_MASK(64'h0)) u2 (
    .clk(clk), .reset(rst2), .enable(en2), .load(ld2), .seed_in(seed2),
    .out_ready(rdy2), .out_valid(v2), .out_data(d2), .state(st2), .lockup(lk2)
  );

  typedef struct {
    logic        rst, en, ld, rdy;
    logic [31:0] seed;
    logic        exp_v;
    logic [31:0] exp_d, exp_s;
    logic        exp_lk;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] sb_q[$];

  function automatic vec_t mk(input logic rst, en, ld, rdy, input logic [31:0] seed,
                              input logic ev, input logic [31:0] ed, es, input logic el);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.rdy = rdy; v.seed = seed;
    v.exp_v = ev; v.exp_d = ed; v.exp_s = es; v.exp_lk = el;
    return v;
  endfunction

  // Reference single step: parity loop over the tap bits, shift left.
  function automatic logic [63:0] mstep(input logic [63:0] s, input int w,
                                        input logic [63:0] taps, input bit xn);
    logic        p;
    logic [63:0] mask;
    p = xn;
    for (int i = 0; i < w; i++) if (taps[i]) p = p ^ s[i];
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    return ((s << 1) | {63'd0, p}) & mask;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] m_state;
    logic        m_valid;
    logic        en, rdy, m_fire;
    logic [63:0] m4;
    int          period;

    rst0 = 0; en0 = 0; ld0 = 0; rdy0 = 0; seed0 = '0;
    rst1 = 1; en1 = 0; ld1 = 0; rdy1 = 0; seed1 = '0;
    rst2 = 1; en2 = 0; ld2 = 0; rdy2 = 0; seed2 = '0;

    // ---------------- table on default instance ----------------
    tbl.push_back(mk(1,0,0,0,32'h0,          0,32'h0000_0000,32'h0FFF_0FFF,0));
    tbl.push_back(mk(0,1,0,1,32'h0,          1,32'h9FFE_9FFE,32'h1FFE_1FFE,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,1,0,0,32'h0,        1,32'h9FFE_9FFE,32'h1FFE_1FFE,0));
    tbl.push_back(mk(0,1,0,1,32'h0,          1,32'hBFFC_BFFD,32'h3FFC_3FFD,0));
    tbl.push_back(mk(0,0,1,0,32'hFFFF_FFFF,  0,32'hBFFC_BFFD,32'h0FFF_0FFF,1));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,32'hBFFC_BFFD,32'h0FFF_0FFF,0));
    tbl.push_back(mk(0,0,1,0,32'h0000_0001,  0,32'hBFFC_BFFD,32'h0000_0001,0));
    tbl.push_back(mk(0,1,1,1,32'h0FFF_0FFF,  0,32'hBFFC_BFFD,32'h0FFF_0FFF,0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'h9FFE_9FFE,32'h1FFE_1FFE,0));
    tbl.push_back(mk(0,0,0,1,32'h0,          0,32'h9FFE_9FFE,32'h1FFE_1FFE,0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'hBFFC_BFFD,32'h3FFC_3FFD,0));
    tbl.push_back(mk(1,1,0,0,32'h0,          0,32'h0000_0000,32'h0FFF_0FFF,0));
    tbl.push_back(mk(0,0,0,1,32'h0,          0,32'h0000_0000,32'h0FFF_0FFF,0));

    foreach (tbl[i]) begin
      rst0 = tbl[i].rst; en0 = tbl[i].en; ld0 = tbl[i].ld;
      rdy0 = tbl[i].rdy; seed0 = tbl[i].seed;
      tick();
      check($sformatf("vec%0d.valid", i), {63'd0, v0}, {63'd0, tbl[i].exp_v});
      check($sformatf("vec%0d.data", i), {32'd0, d0}, {32'd0, tbl[i].exp_d});
      check($sformatf("vec%0d.state", i), {32'd0, st0}, {32'd0, tbl[i].exp_s});
      check($sformatf("vec%0d.lockup", i), {63'd0, lk0}, {63'd0, tbl[i].exp_lk});
    end
    en0 = 0; rdy0 = 0;

    // ---------------- scoreboard on STEPS=2 instance ----------------
    tick();
    rst1 = 0;
    m_state = 32'h0FFF_0FFF;
    m_valid = 0;
    // first word, known constant
    en1 = 1; rdy1 = 1;
    m_state = mstep(mstep({32'd0, m_state}, 32, 64'h8020_0003, 1), 32, 64'h8020_0003, 1);
    sb_q.push_back(m_state | 32'h8000_8000);
    m_valid = 1;
    tick();
    check("s2.first_state", {32'd0, st1}, 64'h3FFC_3FFD);
    check("s2.first_data", {32'd0, d1}, 64'hBFFC_BFFD);
    check("s2.first_valid", {63'd0, v1}, 64'd1);

    for (int c = 0; c < 300; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      rdy = $urandom_range(0, 1) == 1;
      if (v1 && rdy) begin
        if (sb_q.size() == 0) begin
          check("sb.empty_pop", 64'd1, 64'd0);
        end else begin
          check("sb.word", {32'd0, d1}, {32'd0, sb_q.pop_front()});
        end
      end
      m_fire = en && (!m_valid || rdy);
      if (m_fire) begin
        m_state = mstep(mstep({32'd0, m_state}, 32, 64'h8020_0003, 1), 32, 64'h8020_0003, 1);
        if (m_state == 32'hFFFF_FFFF) m_state = 32'h0FFF_0FFF;
        sb_q.push_back(m_state | 32'h8000_8000);
        m_valid = 1;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      en1 = en; rdy1 = rdy;
      tick();
      check("sb.valid", {63'd0, v1}, {63'd0, m_valid});
      check("sb.state", {32'd0, st1}, {32'd0, m_state});
    end
    check("sb.leftover", 64'(sb_q.size()), {63'd0, m_valid});
    en1 = 0; rdy1 = 0;

    // ---------------- 4-bit XOR: period and lock-up reseed ----------------
    tick();
    rst2 = 0;
    check("w4.reset_state", {60'd0, st2}, 64'h1);
    m4 = 64'h1;
    period = 0;
    en2 = 1; rdy2 = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      m4 = mstep(m4, 4, 64'h9, 0);
      period++;
      check("w4.step_state", {60'd0, st2}, m4);
      check("w4.step_data", {60'd0, d2}, m4);
      if (st2 == 4'h1) break;
    end
    check("w4.period", 64'(period), 64'd15);
    en2 = 0; ld2 = 1; seed2 = 4'h0;
    tick();
    check("w4.load0_state", {60'd0, st2}, 64'h1);
    check("w4.load0_lockup", {63'd0, lk2}, 64'd1);
    check("w4.load0_valid", {63'd0, v2}, 64'd0);
    ld2 = 0;
    tick();
    check("w4.lockup_pulse_end", {63'd0, lk2}, 64'd0);
    check("w4.hold_state", {60'd0, st2}, 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
